// File: rtl/craft_pkg.sv
// ---------------------------------------------------------------------------
// craft_pkg
// Shared definitions for the CRAFT round-constant sequencer:
//   - rc_t           : one 8-bit round constant
//   - seq_state_t    : sequencer FSM state encoding
//   - lfsr_*_fwd/inv : single forward / inverse steps of the two LFSRs
//   - make_rc        : packs (a, b) into an 8-bit constant {a, 0, b}
//   - rc_state_at    : {a, b} after n forward steps from RC0
//   - CRAFT_ROUNDS   : default number of rounds per operation
// ---------------------------------------------------------------------------
package craft_pkg;

    typedef logic [7:0] rc_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int         CRAFT_ROUNDS = 32;
    localparam logic [3:0] A_INIT       = 4'h1;
    localparam logic [2:0] B_INIT       = 3'h1;

    // 4-bit LFSR, period 15.
    function automatic logic [3:0] lfsr_a_fwd(input logic [3:0] a);
        return {a[1] ^ a[0], a[3:1]};
    endfunction

    function automatic logic [3:0] lfsr_a_inv(input logic [3:0] a);
        return {a[2:0], a[3] ^ a[0]};
    endfunction

    // 3-bit LFSR, period 7.
    function automatic logic [2:0] lfsr_b_fwd(input logic [2:0] b);
        return {b[1] ^ b[0], b[2:1]};
    endfunction

    function automatic logic [2:0] lfsr_b_inv(input logic [2:0] b);
        return {b[1:0], b[2] ^ b[0]};
    endfunction

    function automatic rc_t make_rc(input logic [3:0] a, input logic [2:0] b);
        return {a, 1'b0, b};
    endfunction

    // Used at elaboration time to derive the reverse-walk start state, so no
    // constant table has to be kept in sync with NUM_ROUNDS.
    function automatic logic [6:0] rc_state_at(input int n);
        logic [3:0] a;
        logic [2:0] b;
        a = A_INIT;
        b = B_INIT;
        for (int i = 0; i < n; i++) begin
            a = lfsr_a_fwd(a);
            b = lfsr_b_fwd(b);
        end
        return {a, b};
    endfunction

endpackage

// File: rtl/craft_rc_lane_chain.sv
// ---------------------------------------------------------------------------
// craft_rc_lane_chain
// Combinational expansion of one registered LFSR state into UNROLL
// consecutive round constants, walking forward or backward.
// Ports:
//   a, b     in   lane-0 LFSR state
//   dir      in   0 = forward steps, 1 = inverse steps
//   lanes    out  8*UNROLL bits, lane k in [8k+7:8k]
//   a_ahead  out  a after UNROLL steps in the selected direction
//   b_ahead  out  b after UNROLL steps in the selected direction
// ---------------------------------------------------------------------------
module craft_rc_lane_chain
    import craft_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic [3:0]          a,
    input  logic [2:0]          b,
    input  logic                dir,
    output logic [8*UNROLL-1:0] lanes,
    output logic [3:0]          a_ahead,
    output logic [2:0]          b_ahead
);

    logic [3:0] a_walk;
    logic [2:0] b_walk;

    // Each lane emits the current state, then the state is stepped once; after
    // the last lane the walked state is exactly the next group's lane 0.
    always_comb begin
        lanes  = '0;
        a_walk = a;
        b_walk = b;
        for (int k = 0; k < UNROLL; k++) begin
            lanes[8*k +: 8] = make_rc(a_walk, b_walk);
            if (dir) begin
                a_walk = lfsr_a_inv(a_walk);
                b_walk = lfsr_b_inv(b_walk);
            end else begin
                a_walk = lfsr_a_fwd(a_walk);
                b_walk = lfsr_b_fwd(b_walk);
            end
        end
        a_ahead = a_walk;
        b_ahead = b_walk;
    end

endmodule

// File: rtl/craft_rc_sequencer.sv
// ---------------------------------------------------------------------------
// craft_rc_sequencer
// Supplies UNROLL consecutive CRAFT round constants per step to an unrolled
// round datapath, walking forward (encryption) or backward (decryption).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin (or restart) an operation
//   dir        in   sampled with start: 0 = forward, 1 = reverse
//   advance    in   datapath consumed the current group
//   rc_vec     out  UNROLL constants, lane k in [8k+7:8k]; 0 when not valid
//   round_idx  out  round number of lane 0; 0 when not valid
//   valid      out  rc_vec / round_idx meaningful
//   last       out  current group is the final one
//   done       out  one-cycle pulse after the final group is consumed
// ---------------------------------------------------------------------------
module craft_rc_sequencer
    import craft_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int NUM_ROUNDS = CRAFT_ROUNDS,
    parameter int IDX_W      = $clog2(NUM_ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dir,
    input  logic                advance,
    output logic [8*UNROLL-1:0] rc_vec,
    output logic [IDX_W-1:0]    round_idx,
    output logic                valid,
    output logic                last,
    output logic                done
);

    localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(UNROLL);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_FWD  = IDX_W'(NUM_ROUNDS - UNROLL);
    localparam logic [IDX_W-1:0] LAST_REV  = IDX_W'(UNROLL - 1);
    localparam logic [6:0]       REV_STATE = rc_state_at(NUM_ROUNDS - 1);
    localparam logic [3:0]       A_REV     = REV_STATE[6:3];
    localparam logic [2:0]       B_REV     = REV_STATE[2:0];

    seq_state_t          state_q, state_d;
    logic [3:0]          a_q, a_d;
    logic [2:0]          b_q, b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic                done_q, done_d;

    logic [8*UNROLL-1:0] lanes;
    logic [3:0]          a_ahead;
    logic [2:0]          b_ahead;
    logic                running;
    logic                is_last;

    craft_rc_lane_chain #(
        .UNROLL (UNROLL)
    ) u_chain (
        .a       (a_q),
        .b       (b_q),
        .dir     (dir_q),
        .lanes   (lanes),
        .a_ahead (a_ahead),
        .b_ahead (b_ahead)
    );

    assign running = (state_q == RUN);
    assign is_last = running && (dir_q ? (idx_q == LAST_REV) : (idx_q == LAST_FWD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= A_INIT;
            b_q     <= B_INIT;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // start beats advance in RUN, so an abort on the final group reloads
    // instead of completing and never raises done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = RUN;
            dir_d   = dir;
            if (dir) begin
                a_d   = A_REV;
                b_d   = B_REV;
                idx_d = IDX_TOP;
            end else begin
                a_d   = A_INIT;
                b_d   = B_INIT;
                idx_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (advance) begin
                        if (is_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            a_d   = a_ahead;
                            b_d   = b_ahead;
                            idx_d = dir_q ? (idx_q - IDX_STEP) : (idx_q + IDX_STEP);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign valid     = running;
    assign last      = is_last;
    assign done      = done_q;
    assign rc_vec    = running ? lanes : '0;
    assign round_idx = running ? idx_q : '0;

endmodule

// File: doc/craft_rc_sequencer.md
Name: craft_rc_sequencer

Overview:
- Parametrised CRAFT round-constant sequencer.
- Produces UNROLL consecutive 8-bit round constants per step for an unrolled round datapath.
- Walks forward for encryption or backward for decryption, tracks the round index, and handshakes with the datapath through valid/advance.
- Sits beside the round function and replaces the fixed single-constant generator.

Parameters:
- UNROLL, 1, constants per step (1, 2, 4 or 8); NUM_ROUNDS must be a multiple of UNROLL.
- NUM_ROUNDS, 32, total rounds per operation (2..64).
- IDX_W, $clog2(NUM_ROUNDS), width of round_idx.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an operation (sampled every cycle).
- dir  in  1  sampled with start: 0 = forward (RC0 upward), 1 = reverse (RC[NUM_ROUNDS-1] downward).
- advance  in  1  datapath has consumed the current group.
- rc_vec  out  8*UNROLL  lane k in bits [8k+7:8k].
- round_idx  out  IDX_W  round number of lane 0.
- valid  out  1  rc_vec/round_idx meaningful.
- last  out  1  current group is the final one.
- done  out  1  one-cycle pulse after the final group is consumed.

Behaviour:
- Constant definition:
  - RC = {a[3:0], 1'b0, b[2:0]}.
  - Forward step: a' = {a[1]^a[0], a[3:1]}; b' = {b[1]^b[0], b[2:1]}.
  - Inverse step: a = {a'[2:0], a'[3]^a'[0]}; b = {b'[1:0], b'[2]^b'[0]}.
  - RC0 has a=4'h1, b=3'h1. Periods: a is 15, b is 7.
- Lane k holds RC[round_idx+k] when forward and RC[round_idx-k] when reverse.
- Lanes are computed combinationally from the registered lane-0 state (a, b) by chaining k forward or inverse steps.
- Step: on accepted advance, the registered state moves UNROLL steps in the active direction. round_idx moves by ±UNROLL.
- Reverse start state is the (a, b) for RC[NUM_ROUNDS-1]. It is computed at elaboration by a package function, not stored in a table.
- States:
  - IDLE: valid=0.
  - RUN: valid=1.
- Transitions:
  - IDLE, start=1 → RUN. Load (a, b) and round_idx (0 or NUM_ROUNDS-1), latch dir. valid rises the next cycle; latency start→valid is 1 cycle.
  - RUN, advance=1, last=0 → RUN, stepped.
  - RUN, advance=1, last=1 → IDLE. done=1 for exactly that following cycle.
  - RUN, start=1 → abort and reload per the new dir; start has priority over advance. No done pulse for the aborted run.
  - advance while IDLE: ignored.
- last=1 when round_idx == NUM_ROUNDS-UNROLL (forward) or round_idx == UNROLL-1 (reverse).
- Outputs hold stable while valid=1 and advance=0.
- Reset (any time, including mid-run):
  - State → IDLE.
  - valid, last and done = 0.
  - rc_vec = 0, round_idx = 0.
  - Internal a=4'h1, b=3'h1; dir latch = 0.
  - First clock after deassertion is idle.
- rc_vec is gated to 0 when valid=0.

Decomposition:
- Shared package craft_pkg holds:
  - typedef rc_t (8 bits);
  - functions lfsr_a_fwd, lfsr_a_inv, lfsr_b_fwd, lfsr_b_inv;
  - function rc_state_at(n), returning {a, b} after n forward steps, used for the reverse start;
  - constant CRAFT_ROUNDS = 32.
- One natural sub-module: craft_rc_lane_chain. Combinational; takes (a, b, dir) and outputs UNROLL lanes plus the (a, b) UNROLL steps ahead.

Test Plan:
1. UNROLL=1, forward. start (dir=0), advance held high. Required response:
   - valid one cycle after start;
   - rc_vec sequence 0x11, 0x84, 0x42, 0x25, 0x96, 0xC7, 0x63, 0xB1, 0x54;
   - RC15 = 0x14 (wrap check);
   - last on round 31 (0x85), done pulse on the next cycle, then valid=0.
2. UNROLL=1, reverse. start (dir=1). Required response:
   - rc_vec 0x85, 0x12, 0x34, … ending at 0x11 with round_idx=0 and last=1.
   - Reverse stream equals the forward stream reversed.
3. UNROLL=4, forward. Required response:
   - first rc_vec = 0x25428411, round_idx=0;
   - after one advance, rc_vec = 0xB163C796, round_idx=4;
   - last at round_idx=28; 8 groups in total.
4. Backpressure and abort:
   - advance low for 5 cycles → rc_vec and round_idx stable.
   - start with dir=1 mid-run → next cycle rc_vec=0x85, round_idx=31, no done pulse.
5. Reset mid-run: assert rst asynchronously between clock edges at round 10 → valid, rc_vec and round_idx go to 0 immediately, without waiting for a clock edge.
6. advance while idle, and start coincident with advance on the last group → no state change while idle; the restart wins over completion.
